// File: rtl/fifo_pkg.sv
// Shared sizing and pointer helpers for the parameterised FIFO.
package fifo_pkg;

  // Width needed to hold every fill level from 0 to depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Wrap-aware increment; valid for any depth, not just powers of two.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module fifo_ram #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto RAM; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en_i && !rst) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with fill-level flags and sticky error flags.
// Define FIFO_SVA_EN to compile in the embedded assertions and covers.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int  WIDTH    = 8,
  parameter int  DEPTH    = 8,
  parameter int  AF_LEVEL = DEPTH - 2,
  parameter int  AE_LEVEL = 1,
  localparam int CNT_W    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_write,
  input  logic             fifo_read,
  input  logic [WIDTH-1:0] fifo_data_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             fifo_almost_full,
  output logic             fifo_almost_empty,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_overflow,
  output logic             fifo_underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_acc, rd_acc, ovf_set, udf_set;

  assign fifo_count        = count_q;
  assign fifo_empty        = (count_q == '0);
  assign fifo_full         = (count_q == CNT_W'(DEPTH));
  assign fifo_almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign fifo_almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = udf_q;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign wr_acc  = fifo_write && (!fifo_full || fifo_read);
  assign rd_acc  = fifo_read && !fifo_empty;
  assign ovf_set = fifo_write && fifo_full && !fifo_read;
  assign udf_set = fifo_read && fifo_empty;

  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (rd_acc) rd_ptr_d = PTR_W'(ptr_inc(int'(rd_ptr_q), DEPTH));
    if (wr_acc) wr_ptr_d = PTR_W'(ptr_inc(int'(wr_ptr_q), DEPTH));
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    udf_d = udf_set | (udf_q & ~clr_err);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (fifo_data_in),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (fifo_data_out)
  );

`ifdef FIFO_SVA_EN
  property p_reset_vals;
    @(posedge clk) disable iff (rst) $past(rst) |->
      (count_q == '0 && rd_ptr_q == '0 && wr_ptr_q == '0 && fifo_data_out == '0 &&
       !fifo_overflow && !fifo_underflow);
  endproperty
  a_reset_vals: assert property (p_reset_vals) else $display("FAIL:: %0d a_reset_vals", $stime);
  c_reset_vals: cover property (p_reset_vals);

  property p_empty;
    @(posedge clk) disable iff (rst) fifo_empty == (count_q == '0);
  endproperty
  a_empty: assert property (p_empty) else $display("FAIL:: %0d a_empty", $stime);
  c_empty: cover property (p_empty);

  property p_full;
    @(posedge clk) disable iff (rst) fifo_full == (count_q > CNT_W'(DEPTH - 1));
  endproperty
  a_full: assert property (p_full) else $display("FAIL:: %0d a_full", $stime);
  c_full: cover property (p_full);

  property p_wr_hold;
    @(posedge clk) disable iff (rst) (fifo_write && fifo_full && !fifo_read) |=> $stable(wr_ptr_q);
  endproperty
  a_wr_hold: assert property (p_wr_hold) else $display("FAIL:: %0d a_wr_hold", $stime);
  c_wr_hold: cover property (p_wr_hold);

  property p_rd_hold;
    @(posedge clk) disable iff (rst) (fifo_read && fifo_empty && !fifo_write) |=> $stable(rd_ptr_q);
  endproperty
  a_rd_hold: assert property (p_rd_hold) else $display("FAIL:: %0d a_rd_hold", $stime);
  c_rd_hold: cover property (p_rd_hold);

  property p_cnt_max;
    @(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH);
  endproperty
  a_cnt_max: assert property (p_cnt_max) else $display("FAIL:: %0d a_cnt_max", $stime);
  c_cnt_max: cover property (p_cnt_max);
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: a DEPTH=8 and a DEPTH=5 instance share stimulus, one is checked at a time.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       rst, fifo_write, fifo_read, clr_err;
  logic [7:0] fifo_data_in;

  logic [7:0] dout8, dout5;
  logic       full8, empty8, af8, ae8, ovf8, udf8;
  logic       full5, empty5, af5, ae5, ovf5, udf5;
  logic [3:0] cnt8;
  logic [2:0] cnt5;

  always #5 clk = ~clk;

  param_fifo #(.WIDTH(8), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .fifo_write(fifo_write), .fifo_read(fifo_read),
    .fifo_data_in(fifo_data_in), .clr_err(clr_err), .fifo_data_out(dout8),
    .fifo_full(full8), .fifo_empty(empty8), .fifo_almost_full(af8),
    .fifo_almost_empty(ae8), .fifo_count(cnt8), .fifo_overflow(ovf8),
    .fifo_underflow(udf8)
  );

  param_fifo #(.WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .fifo_write(fifo_write), .fifo_read(fifo_read),
    .fifo_data_in(fifo_data_in), .clr_err(clr_err), .fifo_data_out(dout5),
    .fifo_full(full5), .fifo_empty(empty5), .fifo_almost_full(af5),
    .fifo_almost_empty(ae5), .fifo_count(cnt5), .fifo_overflow(ovf5),
    .fifo_underflow(udf5)
  );

  bit          sel = 1'b0;
  int          depth = 8;
  logic [7:0]  d_dout;
  logic [31:0] d_cnt;
  logic        d_full, d_empty, d_af, d_ae, d_ovf, d_udf;

  always_comb begin
    d_dout  = sel ? dout5  : dout8;
    d_cnt   = sel ? 32'(cnt5) : 32'(cnt8);
    d_full  = sel ? full5  : full8;
    d_empty = sel ? empty5 : empty8;
    d_af    = sel ? af5    : af8;
    d_ae    = sel ? ae5    : ae8;
    d_ovf   = sel ? ovf5   : ovf8;
    d_udf   = sel ? udf5   : udf8;
  end

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_dout = 8'h00;
  bit         m_ovf = 1'b0, m_udf = 1'b0;
  bit         rd_fire = 1'b0;
  bit         mon_fire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (depth %0d, t=%0t): got 0x%0h, expected 0x%0h", name, depth, $time, act, exp);
    end
  endtask

  // Status outputs compared against the abstract queue model.
  task automatic check_status();
    int n = model_q.size();
    check("count",        d_cnt,   n);
    check("empty",        d_empty, n == 0);
    check("full",         d_full,  n == depth);
    check("almost_full",  d_af,    n >= depth - 2);
    check("almost_empty", d_ae,    n <= 1);
    check("overflow",     d_ovf,   m_ovf);
    check("underflow",    d_udf,   m_udf);
    check("data_out_hold", d_dout, last_dout);
  endtask

  // One clock of stimulus; the model advances to the post-edge state as inputs are driven.
  task automatic step(input bit w, input bit r, input bit c, input bit rs, input logic [7:0] d);
    @(negedge clk);
    check_status();
    fifo_write   = w;
    fifo_read    = r;
    clr_err      = c;
    rst          = rs;
    fifo_data_in = d;
    if (rs) begin
      model_q.delete();
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
      last_dout = 8'h00;
      rd_fire   = 1'b0;
    end else begin
      int n     = model_q.size();
      bit set_o = w && (n == depth) && !r;
      bit set_u = r && (n == 0);
      rd_fire = r && (n > 0);
      if (rd_fire) begin
        last_dout = model_q.pop_front();
        exp_q.push_back(last_dout);
      end
      if (w && (n < depth || r)) model_q.push_back(d);
      m_ovf = set_o | (m_ovf & !c);
      m_udf = set_u | (m_udf & !c);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0, 8'($urandom));
  endtask

  // Monitor: every accepted read must surface the oldest queued word one edge later.
  initial begin
    forever begin
      @(posedge clk);
      mon_fire = rd_fire;
      #1;
      if (mon_fire) begin
        if (exp_q.size() == 0) check("scoreboard_underrun", 32'd1, 32'd0);
        else check("read_data", d_dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fifo_write = 1'b0; fifo_read = 1'b0; clr_err = 1'b0; fifo_data_in = 8'h00;

    // Reset for two cycles, then fill with 0x01..0x08.
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 0, 8'(i));

    // Overflow: rejected write must not disturb contents; flag sticks until clr_err.
    step(1, 0, 0, 0, 8'hAA);
    idle(2);
    step(0, 0, 1, 0, 8'h00);

    // Drain in order, then one extra read on empty.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);

    // Read+write on empty: only the write lands, underflow sets.
    step(1, 1, 0, 0, 8'h55);
    step(0, 1, 0, 0, 8'h00);
    // clr_err coinciding with a new underflow: set wins.
    step(0, 1, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);

    // Read+write on full: count stays at DEPTH, oldest word comes out.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'($urandom));
    step(1, 1, 0, 0, 8'hC3);
    step(1, 1, 0, 0, 8'h3C);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'h00);

    random_run(400);

    // Reset mid-burst with a write pending.
    step(0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'h10 + 8'(i));
    step(1, 1, 1, 1, 8'h77);
    idle(2);

    // Switch to the DEPTH=5 instance: both were reset together above.
    sel   = 1'b1;
    depth = 5;
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 20; i++) step(1, i >= 2, 0, 0, 8'h40 + 8'(i));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 8'h80 + 8'(i));
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 8'h90 + 8'(i));
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 8'h00);
    random_run(400);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (>=2, any integer, not restricted to powers of 2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, fill level at which almost-full asserts (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 1, fill level at which almost-empty asserts (1..DEPTH-1).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port fifo_write  input  1  write request.
REQ-008 SHALL have port fifo_read  input  1  read request.
REQ-009 SHALL have port fifo_data_in  input  WIDTH  write data.
REQ-010 SHALL have port clr_err  input  1  clears the sticky error flags.
REQ-011 SHALL have port fifo_data_out  output  WIDTH  registered read data.
REQ-012 SHALL have ports fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty  output  1 each  status flags.
REQ-013 SHALL have port fifo_count  output  CNT_W  current fill level, where CNT_W = $clog2(DEPTH+1).
REQ-014 SHALL have ports fifo_overflow, fifo_underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL accept a write when fifo_write && (!fifo_full || fifo_read); the write stores fifo_data_in at wr_ptr.
REQ-016 SHALL accept a read when fifo_read && !fifo_empty; fifo_data_out takes mem[rd_ptr] on that edge (1-cycle latency) and holds otherwise.
REQ-017 SHALL wrap rd_ptr/wr_ptr from DEPTH-1 to 0 (modulo DEPTH, correct for non-power-of-2 DEPTH).
REQ-018 SHALL update count +1 on an accepted write only, -1 on an accepted read only, and leave it unchanged on both or neither.
REQ-019 SHALL accept both operations on simultaneous read+write when full: count stays DEPTH, both pointers advance.
REQ-020 SHALL accept only the write on simultaneous read+write when empty: count becomes 1, rd_ptr is unchanged, fifo_data_out is unchanged, underflow is set.
REQ-021 SHALL leave wr_ptr unchanged on a write to a full FIFO without a read; such a write sets fifo_overflow.
REQ-022 SHALL leave rd_ptr unchanged on a read from an empty FIFO; such a read sets fifo_underflow.
REQ-023 SHALL derive all flags combinationally from the count register: fifo_empty = (count==0), fifo_full = (count==DEPTH), fifo_almost_full = (count>=AF_LEVEL), fifo_almost_empty = (count<=AE_LEVEL).
REQ-024 SHALL keep fifo_overflow and fifo_underflow at 1 until clr_err or rst; when clr_err coincides with a new error, the flag SHALL read 1 on the next cycle (set wins).
REQ-025 SHALL never corrupt stored entries on a rejected write.

Reset
REQ-026 SHALL, on rst sampled high, clear rd_ptr, wr_ptr and count to 0, so that fifo_empty=1, fifo_almost_empty=1, fifo_full=0 and fifo_almost_full=0.
REQ-027 SHALL, on reset, clear fifo_data_out to 0 and fifo_overflow and fifo_underflow to 0; memory contents are not reset.
REQ-028 SHALL give rst priority over simultaneous read, write and clr_err, including reset asserted mid-burst.

Configuration
REQ-029 SHALL, when macro FIFO_SVA_EN is defined, compile in embedded concurrent assertions, each disabled iff (rst): reset values per REQ-026/027; empty iff count==0; full iff count>DEPTH-1; wr_ptr stable on write-when-full-without-read; rd_ptr stable on read-when-empty-without-write; count never exceeds DEPTH. Each assertion SHALL be paired with a cover, and failures SHALL $display with $stime and a FAIL:: tag.
REQ-030 SHALL, when FIFO_SVA_EN is undefined, contain no assertion code, with functional behaviour identical to the enabled build.

Structure
REQ-031 SHALL place in shared package fifo_pkg the function cnt_width(depth), returning $clog2(depth+1), and the function ptr_inc(ptr, depth), the wrap-aware increment.
REQ-032 SHALL isolate storage in sub-module fifo_ram: WIDTH x DEPTH, 1 write port, 1 registered read port, same clk.
REQ-033 SHALL keep pointers, count, flags and error logic in param_fifo.

Verification
REQ-034 SHALL verify reset: with DEPTH=8, apply rst for 2 cycles -> count=0, empty=1, full=0, overflow=0, underflow=0, data_out=0.
REQ-035 SHALL verify fill and drain: with DEPTH=8, write 8 words 0x01..0x08 -> full=1 and almost_full from count 6; then read 8 -> outputs 0x01..0x08 in order, each 1 cycle after its read, and empty=1.
REQ-036 SHALL verify overflow: on a full FIFO, write 0xAA without read -> wr_ptr and count unchanged, overflow=1 until clr_err; a later read returns the original data, not 0xAA.
REQ-037 SHALL verify underflow and simultaneous operations: on an empty FIFO, read+write 0x55 -> count=1, underflow=1; on a full FIFO, read+write -> count stays 8 and the oldest word is output.
REQ-038 SHALL verify non-power-of-2 wrap: with DEPTH=5, stream 20 words with interleaved reads -> pointers wrap 4->0 and the output order is preserved.
REQ-039 SHALL verify reset mid-operation: assert rst while count=3 with a write pending -> next cycle count=0 and empty=1, and the pending write is discarded.
